// File: rtl/m2_pkg.sv
// Shared types and memory-map constants for the Milestone 2 IDCT scheduler.
package m2_pkg;

    localparam int unsigned Y_BLOCK_COLS  = 40;
    localparam int unsigned UV_BLOCK_COLS = 20;
    localparam int unsigned BLOCK_ROWS    = 30;

    localparam logic [17:0] PRE_Y_BASE  = 18'd76800;
    localparam logic [17:0] PRE_U_BASE  = 18'd153600;
    localparam logic [17:0] PRE_V_BASE  = 18'd192000;
    localparam logic [17:0] POST_Y_BASE = 18'd0;
    localparam logic [17:0] POST_U_BASE = 18'd38400;
    localparam logic [17:0] POST_V_BASE = 18'd57600;

    localparam logic [8:0] PRE_Y_STRIDE   = 9'd320;
    localparam logic [8:0] PRE_UV_STRIDE  = 9'd160;
    localparam logic [7:0] POST_Y_STRIDE  = 8'd160;
    localparam logic [7:0] POST_UV_STRIDE = 8'd80;

    localparam logic [11:0] LAST_BLOCK = 12'd2399;

    typedef enum logic [2:0] {
        StIdle, StLiFs, StLiCt, StMa, StMb, StLoCs, StLoWs, StFin
    } m2_sched_state_t;

    typedef enum logic [1:0] {PLANE_Y, PLANE_U, PLANE_V} m2_plane_t;

    function automatic logic [5:0] last_col(input m2_plane_t plane);
        return (plane == PLANE_Y) ? 6'(Y_BLOCK_COLS - 1) : 6'(UV_BLOCK_COLS - 1);
    endfunction

endpackage

// File: rtl/m2_block_addr_gen.sv
// Plane/row/col block walker producing the SRAM base address of the current 8x8 block.
module m2_block_addr_gen
    import m2_pkg::*;
#(
    parameter logic [17:0]        YBase    = PRE_Y_BASE,
    parameter logic [17:0]        UBase    = PRE_U_BASE,
    parameter logic [17:0]        VBase    = PRE_V_BASE,
    parameter int unsigned        StrideW  = 9,
    parameter logic [StrideW-1:0] YStride  = StrideW'(320),
    parameter logic [StrideW-1:0] UvStride = StrideW'(160),
    parameter logic [17:0]        ColStep  = 18'd8
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [17:0]        o_base,
    output logic [StrideW-1:0] o_stride
);

    m2_plane_t   r_plane, w_plane_next;
    logic [4:0]  r_row, w_row_next;
    logic [5:0]  r_col, w_col_next;
    logic [17:0] r_row_base, w_row_base_next;
    logic [17:0] r_base, w_base_next;
    logic [17:0] w_row_step;
    logic        w_last_col, w_last_row;

    assign o_stride   = (r_plane == PLANE_Y) ? YStride : UvStride;
    assign w_row_step = 18'({o_stride, 3'b000});
    assign w_last_col = (r_col == last_col(r_plane));
    assign w_last_row = (r_row == 5'(BLOCK_ROWS - 1));
    assign o_base     = r_base;

    always_comb begin
        w_plane_next    = r_plane;
        w_row_next      = r_row;
        w_col_next      = r_col;
        w_row_base_next = r_row_base;
        w_base_next     = r_base;
        if (i_clear) begin
            w_plane_next    = PLANE_Y;
            w_row_next      = 5'd0;
            w_col_next      = 6'd0;
            w_row_base_next = YBase;
            w_base_next     = YBase;
        end else if (i_advance) begin
            if (!w_last_col) begin
                w_col_next  = r_col + 6'd1;
                w_base_next = r_base + ColStep;
            end else if (!w_last_row) begin
                w_col_next      = 6'd0;
                w_row_next      = r_row + 5'd1;
                w_row_base_next = r_row_base + w_row_step;
                w_base_next     = r_row_base + w_row_step;
            end else if (r_plane != PLANE_V) begin
                // Plane change restarts the row-base accumulator at the next plane's origin.
                w_col_next      = 6'd0;
                w_row_next      = 5'd0;
                w_plane_next    = (r_plane == PLANE_Y) ? PLANE_U : PLANE_V;
                w_row_base_next = (r_plane == PLANE_Y) ? UBase : VBase;
                w_base_next     = (r_plane == PLANE_Y) ? UBase : VBase;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_plane    <= PLANE_Y;
            r_row      <= 5'd0;
            r_col      <= 6'd0;
            r_row_base <= YBase;
            r_base     <= YBase;
        end else begin
            r_plane    <= w_plane_next;
            r_row      <= w_row_next;
            r_col      <= w_col_next;
            r_row_base <= w_row_base_next;
            r_base     <= w_base_next;
        end
    end

endmodule

// File: rtl/m2_idct_scheduler.sv
// Milestone 2 sequencer: lead-in, overlapped MA/MB megastates and lead-out over all
// 2400 blocks, with per-block fetch/write address generation.
module m2_idct_scheduler
    import m2_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        Done,
    output logic        fetch_start,
    input  logic        fetch_done,
    output logic [17:0] fetch_base,
    output logic [8:0]  fetch_stride,
    output logic        ct_start,
    input  logic        ct_done,
    output logic        cs_start,
    input  logic        cs_done,
    output logic        write_start,
    input  logic        write_done,
    output logic [17:0] write_base,
    output logic [7:0]  write_stride,
    output logic        busy
);

    m2_sched_state_t r_state, w_state_next;
    // Unit vectors are ordered {fetch, ct, cs, write}.
    logic [3:0]  r_flags, w_wait, w_done_vec, w_accept;
    logic        w_phase_done, w_entry, w_run_start;
    logic [11:0] r_blk;
    logic        r_fetch_start, r_ct_start, r_cs_start, r_write_start, r_done;

    assign w_done_vec   = {fetch_done, ct_done, cs_done, write_done};
    assign w_accept     = w_done_vec & w_wait & ~r_flags;
    assign w_phase_done = (w_wait != 4'b0000) && ((w_wait & ~r_flags) == 4'b0000);
    assign w_run_start  = (r_state == StIdle) && Enable;
    assign w_entry      = (w_state_next != r_state);

    always_comb begin
        w_wait = 4'b0000;
        unique case (r_state)
            StLiFs:  w_wait = 4'b1000;
            StLiCt:  w_wait = 4'b0100;
            StMa:    w_wait = 4'b1010;
            StMb:    w_wait = 4'b0101;
            StLoCs:  w_wait = 4'b0010;
            StLoWs:  w_wait = 4'b0001;
            StIdle,
            StFin:   w_wait = 4'b0000;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (Enable) w_state_next = StLiFs;
            StLiFs: if (w_phase_done) w_state_next = StLiCt;
            StLiCt: if (w_phase_done) w_state_next = StMa;
            StMa:   if (w_phase_done) w_state_next = StMb;
            StMb: begin
                // r_blk + 1 is the block whose CT just finished here.
                if (w_phase_done) begin
                    w_state_next = (r_blk + 12'd1 == LAST_BLOCK) ? StLoCs : StMa;
                end
            end
            StLoCs: if (w_phase_done) w_state_next = StLoWs;
            StLoWs: if (w_phase_done) w_state_next = StFin;
            StFin:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state       <= StIdle;
            r_flags       <= 4'b0000;
            r_blk         <= 12'd0;
            r_fetch_start <= 1'b0;
            r_ct_start    <= 1'b0;
            r_cs_start    <= 1'b0;
            r_write_start <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_flags       <= w_entry ? 4'b0000 : (r_flags | w_accept);
            r_fetch_start <= w_entry && (w_state_next == StLiFs || w_state_next == StMa);
            r_ct_start    <= w_entry && (w_state_next == StLiCt || w_state_next == StMb);
            r_cs_start    <= w_entry && (w_state_next == StMa || w_state_next == StLoCs);
            r_write_start <= w_entry && (w_state_next == StMb || w_state_next == StLoWs);
            r_done        <= w_entry && (w_state_next == StFin);
            if (w_run_start) begin
                r_blk <= 12'd0;
            end else if (r_state == StMb && w_state_next == StMa) begin
                r_blk <= r_blk + 12'd1;
            end
        end
    end

    assign fetch_start = r_fetch_start;
    assign ct_start    = r_ct_start;
    assign cs_start    = r_cs_start;
    assign write_start = r_write_start;
    assign Done        = r_done;
    assign busy        = (r_state != StIdle);

    m2_block_addr_gen #(
        .YBase    (PRE_Y_BASE),
        .UBase    (PRE_U_BASE),
        .VBase    (PRE_V_BASE),
        .StrideW  (9),
        .YStride  (PRE_Y_STRIDE),
        .UvStride (PRE_UV_STRIDE),
        .ColStep  (18'd8)
    ) u_fetch_addr (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .i_clear   (w_run_start),
        .i_advance (w_accept[3]),
        .o_base    (fetch_base),
        .o_stride  (fetch_stride)
    );

    m2_block_addr_gen #(
        .YBase    (POST_Y_BASE),
        .UBase    (POST_U_BASE),
        .VBase    (POST_V_BASE),
        .StrideW  (8),
        .YStride  (POST_Y_STRIDE),
        .UvStride (POST_UV_STRIDE),
        .ColStep  (18'd4)
    ) u_write_addr (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .i_clear   (w_run_start),
        .i_advance (w_accept[0]),
        .o_base    (write_base),
        .o_stride  (write_stride)
    );

endmodule

// File: tb/tb_m2_idct_scheduler.sv
// Scoreboard bench for m2_idct_scheduler: stub units answer starts, a monitor checks
// per-block addresses against queued hand-computed expectations.
module tb_m2_idct_scheduler;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Enable = 1'b0;
    logic        Done, busy;
    logic        fetch_start, ct_start, cs_start, write_start;
    logic        fetch_done, ct_done, cs_done, write_done;
    logic [17:0] fetch_base, write_base;
    logic [8:0]  fetch_stride;
    logic [7:0]  write_stride;

    // {fetch, ct, cs, write}
    logic [3:0] stub_done = 4'b0000;
    logic [3:0] man_done = 4'b0000;
    logic       auto_en = 1'b0;
    int         dly = 3;

    assign {fetch_done, ct_done, cs_done, write_done} = stub_done | man_done;

    always #5 Clock = ~Clock;

    m2_idct_scheduler dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Enable       (Enable),
        .Done         (Done),
        .fetch_start  (fetch_start),
        .fetch_done   (fetch_done),
        .fetch_base   (fetch_base),
        .fetch_stride (fetch_stride),
        .ct_start     (ct_start),
        .ct_done      (ct_done),
        .cs_start     (cs_start),
        .cs_done      (cs_done),
        .write_start  (write_start),
        .write_done   (write_done),
        .write_base   (write_base),
        .write_stride (write_stride),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int idx;
        int base;
        int stride;
    } exp_t;

    exp_t fq[$];
    exp_t wq[$];
    exp_t e;

    int cyc = 0;
    int n_fs, n_ct, n_cs, n_ws, n_wd, n_done;
    int first_fs_cyc, first_ct_cyc, last_wd_cyc, done_cyc;

    // Stub units: done pulse dly cycles after each start (dly 0 = same cycle).
    int cnt[4] = '{-1, -1, -1, -1};
    always @(posedge Clock) begin
        logic [3:0] st;
        #1;
        st = {fetch_start, ct_start, cs_start, write_start};
        for (int i = 0; i < 4; i++) begin
            stub_done[i] = 1'b0;
            if (!Resetn || !auto_en) begin
                cnt[i] = -1;
            end else begin
                if (st[i]) cnt[i] = dly;
                if (cnt[i] == 0) begin
                    stub_done[i] = 1'b1;
                    cnt[i] = -1;
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                end
            end
        end
    end

    // Monitor: count pulses and compare addresses whenever a queued block index starts.
    always @(negedge Clock) begin
        cyc++;
        if (!Resetn) begin
            n_fs = 0; n_ct = 0; n_cs = 0; n_ws = 0; n_wd = 0; n_done = 0;
            first_fs_cyc = 0; first_ct_cyc = 0; last_wd_cyc = 0; done_cyc = 0;
        end else begin
            if (fetch_start) begin
                if (n_fs == 0) first_fs_cyc = cyc;
                if (fq.size() > 0 && fq[0].idx == n_fs) begin
                    e = fq.pop_front();
                    check($sformatf("fetch_base[%0d]", e.idx), int'(fetch_base), e.base);
                    check($sformatf("fetch_stride[%0d]", e.idx), int'(fetch_stride), e.stride);
                end
                n_fs++;
            end
            if (ct_start) begin
                if (n_ct == 0) first_ct_cyc = cyc;
                n_ct++;
            end
            if (cs_start) n_cs++;
            if (write_start) begin
                if (wq.size() > 0 && wq[0].idx == n_ws) begin
                    e = wq.pop_front();
                    check($sformatf("write_base[%0d]", e.idx), int'(write_base), e.base);
                    check($sformatf("write_stride[%0d]", e.idx), int'(write_stride), e.stride);
                end
                n_ws++;
            end
            if (write_done) begin
                n_wd++;
                if (n_wd == 2400) last_wd_cyc = cyc;
            end
            if (Done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    function automatic int cnt_of(input int which);
        case (which)
            0: return n_fs;
            1: return n_ct;
            2: return n_cs;
            3: return n_ws;
            default: return n_done;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int limit,
                            input string name);
        int t = 0;
        while (cnt_of(which) < target && t < limit) begin
            @(negedge Clock);
            t++;
        end
        check(name, int'(cnt_of(which) >= target), 1);
    endtask

    task automatic man_pulse(input logic [3:0] v);
        @(posedge Clock); #1; man_done = v;
        @(posedge Clock); #1; man_done = 4'b0000;
    endtask

    task automatic pulse_enable();
        @(negedge Clock); Enable = 1'b1;
        @(negedge Clock); Enable = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock); Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " Done"}, int'(Done), 0);
        check({tag, " starts"}, int'({fetch_start, ct_start, cs_start, write_start}), 0);
        check({tag, " fetch_base"}, int'(fetch_base), 76800);
        check({tag, " write_base"}, int'(write_base), 0);
        check({tag, " fetch_stride"}, int'(fetch_stride), 320);
        check({tag, " write_stride"}, int'(write_stride), 160);
    endtask

    task automatic check_drained(input string tag);
        check({tag, " fetch queue left"}, fq.size(), 0);
        check({tag, " write queue left"}, wq.size(), 0);
    endtask

    // Hand-computed block addresses: Y/U/V corners, row wraps and plane changes.
    int idx_t[11] = '{0, 39, 40, 80, 1199, 1200, 1201, 1220, 1799, 1800, 2399};
    int fb_t[11]  = '{76800, 77112, 79360, 81920, 151352, 153600, 153608, 154880,
                      190872, 192000, 229272};
    int fs_t[11]  = '{320, 320, 320, 320, 320, 160, 160, 160, 160, 160, 160};
    int wb_t[11]  = '{0, 156, 1280, 2560, 37276, 38400, 38404, 39040, 57036, 57600, 76236};
    int ws_t[11]  = '{160, 160, 160, 160, 160, 80, 80, 80, 80, 80, 80};

    initial begin
        // Reset state, then a full run with 3-cycle stubs.
        do_reset();
        @(negedge Clock);
        check_reset_outputs("reset");
        for (int i = 0; i < 11; i++) begin
            fq.push_back('{idx_t[i], fb_t[i], fs_t[i]});
            wq.push_back('{idx_t[i], wb_t[i], ws_t[i]});
        end
        dly = 3;
        auto_en = 1'b1;
        pulse_enable();
        check("fetch_start after Enable", int'(fetch_start), 1);
        check("busy after Enable", int'(busy), 1);
        wait_for(1, 1, 20, "first ct_start seen");
        check("fetch_start to ct_start gap", first_ct_cyc - first_fs_cyc, 5);
        wait_for(4, 1, 30000, "run A Done seen");
        repeat (5) @(negedge Clock);
        check("run A fetch starts", n_fs, 2400);
        check("run A ct starts", n_ct, 2400);
        check("run A cs starts", n_cs, 2400);
        check("run A write starts", n_ws, 2400);
        check("run A Done count", n_done, 1);
        check("run A last write_done to Done", done_cyc - last_wd_cyc, 2);
        check("run A busy at end", int'(busy), 0);
        check_drained("run A");

        // Manual done ordering inside MA.
        auto_en = 1'b0;
        do_reset();
        fq.push_back('{0, 76800, 320});
        fq.push_back('{1, 76808, 320});
        fq.push_back('{2, 76816, 320});
        wq.push_back('{0, 0, 160});
        wq.push_back('{1, 4, 160});
        pulse_enable();
        wait_for(0, 1, 10, "manual LI fetch_start");
        man_pulse(4'b1000);
        wait_for(1, 1, 10, "manual LI ct_start");
        man_pulse(4'b0100);
        wait_for(2, 1, 10, "manual MA cs_start");
        check("MA fetch_start count", n_fs, 2);
        man_pulse(4'b1010);
        repeat (5) @(negedge Clock);
        check("MB after joint done: ct", n_ct, 2);
        check("MB after joint done: ws", n_ws, 1);
        man_pulse(4'b0101);
        repeat (5) @(negedge Clock);
        check("MA re-entry fetch count", n_fs, 3);
        check("MA re-entry cs count", n_cs, 2);
        man_pulse(4'b1000);
        repeat (3) @(negedge Clock);
        man_pulse(4'b0001);
        repeat (3) @(negedge Clock);
        check("MA holds with only fetch_done", n_ct, 2);
        check("stray write_done in MA", n_ws, 1);
        man_pulse(4'b0010);
        repeat (5) @(negedge Clock);
        check("MB after split done: ct", n_ct, 3);
        check("MB after split done: ws", n_ws, 2);
        repeat (10) @(negedge Clock);
        check("single MB entry", n_ct, 3);
        check_drained("manual");

        // Zero-delay full run with a stray Enable in the middle.
        do_reset();
        fq.push_back('{2399, 229272, 160});
        wq.push_back('{2399, 76236, 80});
        dly = 0;
        auto_en = 1'b1;
        pulse_enable();
        wait_for(0, 1000, 5000, "run B reached block 1000");
        pulse_enable();
        wait_for(4, 1, 12000, "run B Done seen");
        repeat (5) @(negedge Clock);
        check("run B fetch starts", n_fs, 2400);
        check("run B write starts", n_ws, 2400);
        check("run B cs starts", n_cs, 2400);
        check("run B Done count", n_done, 1);
        check("run B last write_done to Done", done_cyc - last_wd_cyc, 2);
        check("run B idle after Done", int'(busy), 0);
        check_drained("run B");

        // Asynchronous reset during MB of block 500, then restart.
        do_reset();
        fq.push_back('{0, 76800, 320});
        fq.push_back('{500, 107680, 320});
        wq.push_back('{500, 15440, 160});
        pulse_enable();
        wait_for(3, 501, 4000, "reached MB of block 500");
        check("busy before mid-run reset", int'(busy), 1);
        #2;
        Resetn = 1'b0;
        #1;
        check_reset_outputs("async reset");
        repeat (3) @(negedge Clock);
        check_drained("pre-restart");
        Resetn = 1'b1;
        fq.push_back('{0, 76800, 320});
        pulse_enable();
        wait_for(0, 1, 10, "restart fetch_start");
        repeat (2) @(negedge Clock);
        check_drained("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
